// File: rtl/reservation_station_n.sv
// Reservation station: allocates dispatched ops, wakes operands from result buses, issues ready entries.
// Define RS_AGE_ORDER_EN for oldest-first issue via an age matrix; otherwise the lowest eligible index issues.
module reservation_station_n #(
  parameter int  ENTRIES  = 4,
  parameter int  ROB_SIZE = 16,
  parameter int  BUSES    = 3,
  parameter int  CMD_W    = 10,
  localparam int TAG_W    = $clog2(ROB_SIZE + 1),
  localparam int CNT_W    = $clog2(ENTRIES + 1),
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        wr_en_i,
  input  logic [TAG_W-1:0]            wr_tag_i,
  input  logic [2:0][TAG_W-1:0]       wr_src_tag_i,
  input  logic [2:0][64:0]            wr_src_val_i,
  input  logic [CMD_W-1:0]            wr_cmd_i,
  output logic                        full_o,
  output logic [CNT_W-1:0]            count_o,
  input  logic [BUSES-1:0][TAG_W-1:0] bus_tag_i,
  input  logic [BUSES-1:0][64:0]      bus_val_i,
  output logic                        issue_valid_o,
  input  logic                        issue_ready_i,
  output logic [2:0][63:0]            issue_val_o,
  output logic [CMD_W-1:0]            issue_cmd_o,
  output logic [TAG_W-1:0]            issue_tag_o
);

  logic [ENTRIES-1:0]                 busy_q;
  logic [ENTRIES-1:0][2:0]            rdy_q;
  logic [ENTRIES-1:0][2:0][TAG_W-1:0] src_tag_q;
  logic [ENTRIES-1:0][2:0][63:0]      data_q;
  logic [ENTRIES-1:0][CMD_W-1:0]      cmd_q;
  logic [ENTRIES-1:0][TAG_W-1:0]      tag_q;

  logic [ENTRIES-1:0][2:0][64:0]      wake;      // {hit, data} per stored operand
  logic [2:0][64:0]                   alloc_val; // {ready, data} per incoming operand
  logic [ENTRIES-1:0]                 eligible;
  logic [ENTRIES-1:0]                 candidate;
  logic                               alloc_ok;
  logic                               sel_found;
  logic                               issue_fire;
  logic [IDX_W-1:0]                   alloc_idx;
  logic [IDX_W-1:0]                   sel_idx;

  function automatic logic [64:0] bus_match(input logic [TAG_W-1:0]            tag,
                                            input logic [BUSES-1:0][TAG_W-1:0] btag,
                                            input logic [BUSES-1:0][64:0]      bval);
    logic [64:0] hit;
    hit = '0;
    // Scan downward so the lowest-numbered matching bus is the one left standing.
    for (int b = BUSES - 1; b >= 0; b--)
      if (bval[b][64] && btag[b] == tag) hit = bval[b];
    return hit;
  endfunction

  // NOTE: every always_comb output gets a default before any conditional logic, so no latch is inferred.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < ENTRIES; i++) count_o = count_o + CNT_W'(busy_q[i]);
  end

  assign full_o   = &busy_q;
  assign alloc_ok = wr_en_i && !full_o;

  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      eligible[i] = busy_q[i] && (&rdy_q[i]);
      for (int k = 0; k < 3; k++) wake[i][k] = bus_match(src_tag_q[i][k], bus_tag_i, bus_val_i);
    end
    for (int k = 0; k < 3; k++)
      alloc_val[k] = wr_src_val_i[k][64] ? wr_src_val_i[k]
                                         : bus_match(wr_src_tag_i[k], bus_tag_i, bus_val_i);
  end

`ifdef RS_AGE_ORDER_EN
  logic [ENTRIES-1:0][ENTRIES-1:0] older_q; // older_q[i][j]: entry i was allocated before entry j

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      candidate[i] = eligible[i];
      for (int j = 0; j < ENTRIES; j++)
        if (j != i && eligible[j] && !older_q[i][j]) candidate[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      older_q <= '0;
    end else if (alloc_ok) begin
      for (int j = 0; j < ENTRIES; j++) begin
        older_q[alloc_idx][j] <= 1'b0;
        older_q[j][alloc_idx] <= (IDX_W'(j) != alloc_idx);
      end
    end
  end
`else
  assign candidate = eligible;
`endif

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (candidate[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
  end

  assign issue_fire = sel_found && issue_ready_i;

  // NOTE: non-blocking assignments sample pre-edge state; a later assignment to the same bit wins.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_q <= '0;
      rdy_q  <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++)
        for (int k = 0; k < 3; k++)
          if (busy_q[i] && !rdy_q[i][k] && wake[i][k][64]) rdy_q[i][k] <= 1'b1;
      if (issue_fire) busy_q[sel_idx] <= 1'b0;
      if (alloc_ok) begin
        busy_q[alloc_idx] <= 1'b1;
        for (int k = 0; k < 3; k++) rdy_q[alloc_idx][k] <= alloc_val[k][64];
      end
    end
  end

  // NOTE: payload storage is deliberately not reset; busy/ready bits gate every use of it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < ENTRIES; i++)
      for (int k = 0; k < 3; k++)
        if (busy_q[i] && !rdy_q[i][k] && wake[i][k][64]) data_q[i][k] <= wake[i][k][63:0];
    if (alloc_ok) begin
      tag_q[alloc_idx] <= wr_tag_i;
      cmd_q[alloc_idx] <= wr_cmd_i;
      for (int k = 0; k < 3; k++) begin
        data_q[alloc_idx][k]    <= alloc_val[k][63:0];
        src_tag_q[alloc_idx][k] <= wr_src_tag_i[k];
      end
    end
  end

  always_comb begin
    issue_valid_o = sel_found;
    issue_val_o   = '0;
    issue_cmd_o   = '0;
    issue_tag_o   = '0;
    if (sel_found) begin
      issue_val_o = data_q[sel_idx];
      issue_cmd_o = cmd_q[sel_idx];
      issue_tag_o = tag_q[sel_idx];
    end
  end

endmodule

// File: doc/reservation_station_n.md
RESERVATION_STATION_N -- requirements
Module: reservation_station_n

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, number of station entries (2..16).
REQ-002 SHALL have parameter ROB_SIZE, default 16; TAG_W = $clog2(ROB_SIZE+1).
REQ-003 SHALL have parameter BUSES, default 3, number of result-broadcast buses (bus 0 highest priority).
REQ-004 SHALL have parameter CMD_W, default 10, command width; operand data fixed at 64 bits plus 1 ready bit.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 reset_n_i  in  1  reset, asynchronous, active-low.
REQ-007 wr_en_i  in  1  decode requests allocation.
REQ-008 wr_tag_i  in  TAG_W  destination ROB tag of dispatched op.
REQ-009 wr_src_tag_i  in  3xTAG_W  producer tag per operand.
REQ-010 wr_src_val_i  in  3x65  per operand {ready, data[63:0]}.
REQ-011 wr_cmd_i  in  CMD_W  command.
REQ-012 full_o  out  1  no free entry; decode stalls.
REQ-013 count_o  out  $clog2(ENTRIES+1)  busy entries.
REQ-014 bus_tag_i  in  BUSESxTAG_W  broadcast tag per bus.
REQ-015 bus_val_i  in  BUSESx65  {valid, data}; bit 64 low = bus idle.
REQ-016 issue_valid_o  out  1  a fully-ready entry is selected.
REQ-017 issue_ready_i  in  1  downstream accepts (low = stall).
REQ-018 issue_val_o  out  3x64, issue_cmd_o  out  CMD_W, issue_tag_o  out  TAG_W  selected entry contents.

Function
REQ-019 full_o SHALL equal AND of registered busy bits; count_o SHALL equal popcount of busy bits.
REQ-020 wr_en_i & ~full_o SHALL allocate the lowest-index non-busy entry at the next edge; wr_en_i while full_o SHALL be ignored.
REQ-021 Per operand at allocation: ready bit set -> stored ready; else if any valid bus tag matches wr_src_tag_i -> capture that bus data as ready (dispatch-time forwarding); else store tag, not ready.
REQ-022 Each busy not-ready operand SHALL capture data and become ready at the edge after a valid bus with matching tag; multiple matches -> lowest bus index wins.
REQ-023 Entry eligible when busy and all 3 operands ready; earliest issue one cycle after allocation.
REQ-024 issue_valid_o SHALL be combinational OR of eligibility; outputs SHALL show the selected entry, all-zero when issue_valid_o low.
REQ-025 issue_valid_o & issue_ready_i SHALL clear the selected entry busy bit at that edge; selection SHALL not change while held by issue_ready_i low unless an older entry becomes eligible.
REQ-026 Entry freed in a cycle SHALL not be re-allocated that same cycle; simultaneous issue and write to a different free entry SHALL both take effect; count_o adjusts by net change.
REQ-027 Tag compare SHALL be full TAG_W equality; tag 0 SHALL be treated as a normal tag.

Reset
REQ-028 reset_n_i low SHALL immediately clear all busy bits, operand ready bits, age state; full_o=0, count_o=0, issue_valid_o=0, data outputs 0.
REQ-029 Reset asserted mid-operation SHALL discard all held entries; first allocation after deassertion uses entry 0.

Configuration
REQ-030 Macro RS_AGE_ORDER_EN defined: SHALL maintain an ENTRIES x ENTRIES age matrix updated on allocation; selection = oldest eligible entry.
REQ-031 RS_AGE_ORDER_EN undefined: no age state; selection = lowest-index eligible entry; all other behaviour identical.

Verification
REQ-032 Reset, write 4 ready ops tags 3,6,9,12 with issue_ready_i=0 -> full_o=1, count_o=4; 5th write ignored; release -> tags issue one per cycle, count_o to 0.
REQ-033 Write op tag 5 with operand1 waiting tag 2, bus1 broadcasts {1,64'hA0} tag 2 next cycle -> issue_valid_o next cycle, issue_val_o[1]=64'hA0.
REQ-034 Write waiting on tag 7 while bus0 carries tag 7 same cycle -> operand captured at allocation, issue one cycle later.
REQ-035 Bus0 and bus2 both broadcast tag 4 with 64'h1 / 64'h2 -> waiting operand gets 64'h1; bus with bit 64 low and matching tag -> no wake.
REQ-036 RS_AGE_ORDER_EN defined: allocate A into entry 1 then B into entry 0 (after entry 0 freed), both ready -> A issues first; undefined -> B first.
REQ-037 Assert reset_n_i mid-cycle with 3 busy entries -> outputs zero immediately, no issue after deassertion until new writes.
